// File: rtl/mem_ctrl.sv
// Memory-access stage: decodes load/store ops and drives a req/ack data bus.
// It stalls the pipeline until the access completes, then aligns load data for MEM/WB.
package mem_ctrl_pkg;
    typedef logic [7:0] AluOpBus;
    localparam AluOpBus EXE_LD_B_OP  = 8'h20;
    localparam AluOpBus EXE_LD_H_OP  = 8'h21;
    localparam AluOpBus EXE_LD_W_OP  = 8'h22;
    localparam AluOpBus EXE_LD_BU_OP = 8'h23;
    localparam AluOpBus EXE_LD_HU_OP = 8'h24;
    localparam AluOpBus EXE_ST_B_OP  = 8'h28;
    localparam AluOpBus EXE_ST_H_OP  = 8'h29;
    localparam AluOpBus EXE_ST_W_OP  = 8'h2A;
endpackage

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [4:0]        mem_wd,
    input  logic              mem_wreg,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_inst_valid,
    input  logic [31:0]       mem_inst_pc,
    input  AluOpBus           mem_aluop,
    input  logic [31:0]       mem_mem_addr,
    input  logic [31:0]       mem_reg2,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [31:0]       wb_wdata,
    output logic              wb_inst_valid,
    output logic [31:0]       wb_inst_pc,
    output logic              ale,
    output logic              stall_req,
    output logic              data_req,
    output logic              data_we,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_ack,
    input  logic [31:0]       data_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_req, w_req_nxt, r_we, w_we_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [3:0]          r_strb, w_strb_nxt;
    logic [31:0]         r_wdata, w_wdata_nxt, r_rbuf, w_rbuf_nxt;

    logic        w_ld, w_st, w_b, w_h, w_w, w_uns;
    logic [1:0]  w_a;
    logic        w_memop, w_mis, w_go;
    logic [3:0]  w_strb;
    logic [31:0] w_sdata, w_ldata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_ld = 1'b0; w_st = 1'b0; w_b = 1'b0; w_h = 1'b0; w_w = 1'b0; w_uns = 1'b0;
        case (mem_aluop)
            EXE_LD_B_OP:  begin w_ld = 1'b1; w_b = 1'b1; end
            EXE_LD_H_OP:  begin w_ld = 1'b1; w_h = 1'b1; end
            EXE_LD_W_OP:  begin w_ld = 1'b1; w_w = 1'b1; end
            EXE_LD_BU_OP: begin w_ld = 1'b1; w_b = 1'b1; w_uns = 1'b1; end
            EXE_LD_HU_OP: begin w_ld = 1'b1; w_h = 1'b1; w_uns = 1'b1; end
            EXE_ST_B_OP:  begin w_st = 1'b1; w_b = 1'b1; end
            EXE_ST_H_OP:  begin w_st = 1'b1; w_h = 1'b1; end
            EXE_ST_W_OP:  begin w_st = 1'b1; w_w = 1'b1; end
            default: ;
        endcase
    end

    assign w_a     = mem_mem_addr[1:0];
    assign w_memop = mem_inst_valid & (w_ld | w_st);
    assign w_mis   = (w_h & w_a[0]) | (w_w & (w_a != 2'b00));
    assign w_go    = w_memop & ~w_mis;
    assign ale     = w_memop & w_mis;
    // DONE drops the stall so EX/MEM and MEM/WB advance on the DONE edge.
    assign stall_req = (w_go & ((r_state == S_IDLE) | (r_state == S_WAIT))) | (r_state == S_DRAIN);

    assign w_strb  = w_b ? (4'b0001 << w_a) : w_h ? (4'b0011 << w_a) : 4'b1111;
    assign w_sdata = w_b ? {4{mem_reg2[7:0]}} : w_h ? {2{mem_reg2[15:0]}} : mem_reg2;

    assign w_byte  = r_rbuf[{w_a, 3'b000} +: 8];
    assign w_half  = w_a[1] ? r_rbuf[31:16] : r_rbuf[15:0];
    assign w_ldata = w_b ? {{24{~w_uns & w_byte[7]}}, w_byte}
                   : w_h ? {{16{~w_uns & w_half[15]}}, w_half}
                   : r_rbuf;

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_strb_nxt  = r_strb;
        w_wdata_nxt = r_wdata;
        w_rbuf_nxt  = r_rbuf;
        case (r_state)
            S_IDLE: if (w_go & ~flush) begin
                w_req_nxt   = 1'b1;
                w_we_nxt    = w_st;
                w_addr_nxt  = {mem_mem_addr[ADDR_W-1:2], 2'b00};
                w_strb_nxt  = w_st ? w_strb : 4'b0000;
                w_wdata_nxt = w_st ? w_sdata : 32'h0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: if (data_ack) begin
                w_req_nxt   = 1'b0;
                w_rbuf_nxt  = data_rdata;
                w_state_nxt = flush ? S_DRAIN : S_DONE;
            end else if (flush) begin
                w_state_nxt = S_DRAIN;
            end
            // A drain entered on the ack edge has nothing outstanding; leave after one cycle.
            S_DRAIN: if (data_ack | ~r_req) begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_strb  <= 4'b0000;
            r_wdata <= 32'h0;
            r_rbuf  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_strb  <= w_strb_nxt;
            r_wdata <= w_wdata_nxt;
            r_rbuf  <= w_rbuf_nxt;
        end
    end

    assign data_req   = r_req;
    assign data_we    = r_we;
    assign data_addr  = r_addr;
    assign data_wstrb = r_strb;
    assign data_wdata = r_wdata;

    assign wb_wd         = flush ? 5'd0  : mem_wd;
    assign wb_wreg       = flush ? 1'b0  : (mem_wreg & ~ale);
    assign wb_wdata      = flush ? 32'h0 : (w_ld ? w_ldata : mem_wdata);
    assign wb_inst_valid = flush ? 1'b0  : mem_inst_valid;
    assign wb_inst_pc    = flush ? 32'h0 : mem_inst_pc;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the stage.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, mem_wreg, mem_inst_valid, data_ack;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_inst_pc, mem_mem_addr, mem_reg2, data_rdata;
    AluOpBus     mem_aluop;
    logic [4:0]  wb_wd;
    logic        wb_wreg, wb_inst_valid, ale, stall_req, data_req, data_we;
    logic [31:0] wb_wdata, wb_inst_pc, data_addr, data_wdata;
    logic [3:0]  data_wstrb;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_inst_valid(mem_inst_valid), .mem_inst_pc(mem_inst_pc),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_inst_valid(wb_inst_valid), .wb_inst_pc(wb_inst_pc),
        .ale(ale), .stall_req(stall_req),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata)
    );

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Access size in bytes; 0 for non-memory ops.
    function automatic int sz(input AluOpBus op);
        case (op)
            EXE_LD_B_OP, EXE_LD_BU_OP, EXE_ST_B_OP: return 1;
            EXE_LD_H_OP, EXE_LD_HU_OP, EXE_ST_H_OP: return 2;
            EXE_LD_W_OP, EXE_ST_W_OP:               return 4;
            default:                                return 0;
        endcase
    endfunction
    function automatic bit is_st(input AluOpBus op);
        return op == EXE_ST_B_OP || op == EXE_ST_H_OP || op == EXE_ST_W_OP;
    endfunction
    function automatic bit is_uns(input AluOpBus op);
        return op == EXE_LD_BU_OP || op == EXE_LD_HU_OP;
    endfunction
    function automatic logic [31:0] ld_align(input AluOpBus op, input logic [31:0] w, input logic [1:0] a);
        logic [31:0] s;
        case (sz(op))
            1: begin
                s = w >> (8 * a);
                return is_uns(op) ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            end
            2: begin
                s = a[1] ? (w >> 16) : w;
                return is_uns(op) ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            end
            default: return w;
        endcase
    endfunction

    // Model: one outstanding bus transaction, plus "result owed" and "squashed" flags.
    bit          m_req, m_keep, m_drop, m_we;
    logic [31:0] m_rbuf, m_addr, m_wdata;
    logic [3:0]  m_strb;

    always @(posedge clk) begin
        int n; bit memop, mis; logic [1:0] a;
        n = sz(mem_aluop); a = mem_mem_addr[1:0];
        memop = mem_inst_valid && n != 0;
        mis = (n == 2 && a[0]) || (n == 4 && a != 2'b00);
        if (!rst) begin
            m_req = 0; m_keep = 0; m_drop = 0; m_we = 0;
            m_rbuf = 0; m_addr = 0; m_wdata = 0; m_strb = 0;
        end else if (m_keep) begin
            m_keep = 0;
        end else if (m_drop) begin
            if (!m_req || data_ack) begin m_drop = 0; m_req = 0; end
        end else if (m_req) begin
            if (data_ack) begin
                m_req = 0; m_rbuf = data_rdata;
                if (flush) m_drop = 1; else m_keep = 1;
            end else if (flush) m_drop = 1;
        end else if (memop && !mis && !flush) begin
            m_req  = 1;
            m_we   = is_st(mem_aluop);
            m_addr = mem_mem_addr & 32'hFFFF_FFFC;
            m_strb = !m_we ? 4'h0 : (n == 1) ? (4'b0001 << a) : (n == 2) ? (4'b0011 << a) : 4'hF;
            m_wdata = !m_we ? 32'h0 : (n == 1) ? {4{mem_reg2[7:0]}}
                    : (n == 2) ? {2{mem_reg2[15:0]}} : mem_reg2;
        end
    end

    always @(negedge clk) if (chk_en) begin
        int n; bit memop, mis, e_ale; logic [1:0] a;
        n = sz(mem_aluop); a = mem_mem_addr[1:0];
        memop = mem_inst_valid && n != 0;
        mis = (n == 2 && a[0]) || (n == 4 && a != 2'b00);
        e_ale = memop && mis;
        chk("ale", 32'(ale), 32'(e_ale));
        chk("stall_req", 32'(stall_req), 32'(m_drop ? 1'b1 : m_keep ? 1'b0 : (memop && !mis)));
        chk("data_req", 32'(data_req), 32'(m_req));
        chk("data_we", 32'(data_we), 32'(m_we));
        chk("data_addr", data_addr, m_addr);
        chk("data_wstrb", 32'(data_wstrb), 32'(m_strb));
        chk("data_wdata", data_wdata, m_wdata);
        chk("wb_wd", 32'(wb_wd), flush ? 32'h0 : 32'(mem_wd));
        chk("wb_wreg", 32'(wb_wreg), flush ? 32'h0 : 32'(mem_wreg && !e_ale));
        chk("wb_wdata", wb_wdata, flush ? 32'h0 :
            (n != 0 && !is_st(mem_aluop)) ? ld_align(mem_aluop, m_rbuf, a) : mem_wdata);
        chk("wb_inst_valid", 32'(wb_inst_valid), flush ? 32'h0 : 32'(mem_inst_valid));
        chk("wb_inst_pc", wb_inst_pc, flush ? 32'h0 : mem_inst_pc);
    end

    task automatic bubble();
        mem_inst_valid = 0; mem_aluop = 8'h00; mem_mem_addr = 0; mem_reg2 = 0;
        mem_wd = 5'd7; mem_wreg = 1; mem_wdata = 32'h5555_AAAA; mem_inst_pc = 32'h1000;
    endtask

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb;
    logic        cap_we;

    // Presents one instruction, acks on the (waits+1)-th request cycle, returns at the first unstalled cycle.
    task automatic run_op(input AluOpBus op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] rd, input int waits, output int nst, output int nreq,
                          output logic [31:0] wbd, output logic wreg_o, output logic ale_o);
        bit done = 0;
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2; mem_inst_valid = 1; mem_wreg = 1;
        data_rdata = rd; nst = 0; nreq = 0; wbd = 0; wreg_o = 0; ale_o = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (data_req) begin
                nreq++;
                if (nreq == 1) begin
                    cap_addr = data_addr; cap_we = data_we; cap_strb = data_wstrb; cap_wdata = data_wdata;
                end
            end
            if (!stall_req) begin
                done = 1; wbd = wb_wdata; wreg_o = wb_wreg; ale_o = ale;
            end else begin
                nst++;
                data_ack = data_req && (nreq == waits + 1);
            end
            @(posedge clk); #1;
            data_ack = 0;
        end
        if (!done) chk("run_op_timeout", 32'd0, 32'd1);
        bubble();
    endtask

    task automatic new_inst();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0: mem_aluop = EXE_LD_B_OP;  1: mem_aluop = EXE_LD_H_OP;  2: mem_aluop = EXE_LD_W_OP;
            3: mem_aluop = EXE_LD_BU_OP; 4: mem_aluop = EXE_LD_HU_OP; 5: mem_aluop = EXE_ST_B_OP;
            6: mem_aluop = EXE_ST_H_OP;  7: mem_aluop = EXE_ST_W_OP;  8: mem_aluop = 8'h01;
            default: mem_aluop = 8'h0F;
        endcase
        mem_mem_addr = $urandom;
        if ($urandom_range(0, 1) == 1) mem_mem_addr[1:0] = 2'b00;
        mem_reg2 = $urandom; mem_wdata = $urandom; mem_wd = 5'($urandom);
        mem_wreg = 1'($urandom); mem_inst_pc = $urandom;
        mem_inst_valid = ($urandom_range(0, 7) != 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int nst, nreq; logic [31:0] wbd; logic wreg_o, ale_o; bit adv;
        rst = 0; flush = 0; data_ack = 0; data_rdata = 0;
        bubble();
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_data_req", 32'(data_req), 32'd0);
        chk("reset_stall", 32'(stall_req), 32'd0);
        chk("reset_wstrb", 32'(data_wstrb), 32'd0);
        @(posedge clk); #1 rst = 1;

        // Zero-wait word load
        run_op(EXE_LD_W_OP, 32'h100, 32'h0, 32'hDEADBEEF, 0, nst, nreq, wbd, wreg_o, ale_o);
        chk("zw_stall_cycles", 32'(nst), 32'd2);
        chk("zw_req_cycles", 32'(nreq), 32'd1);
        chk("zw_wdata", wbd, 32'hDEADBEEF);

        // Byte loads, signed and unsigned, from the top lane
        run_op(EXE_LD_B_OP, 32'h103, 32'h0, 32'h80112233, 1, nst, nreq, wbd, wreg_o, ale_o);
        chk("ldb_wdata", wbd, 32'hFFFFFF80);
        run_op(EXE_LD_BU_OP, 32'h103, 32'h0, 32'h80112233, 0, nst, nreq, wbd, wreg_o, ale_o);
        chk("ldbu_wdata", wbd, 32'h00000080);

        // Halfword store in the upper half, three wait cycles
        run_op(EXE_ST_H_OP, 32'h202, 32'h0000ABCD, 32'h0, 3, nst, nreq, wbd, wreg_o, ale_o);
        chk("sth_addr", cap_addr, 32'h200);
        chk("sth_wstrb", 32'(cap_strb), 32'hC);
        chk("sth_wdata", cap_wdata, 32'hABCDABCD);
        chk("sth_we", 32'(cap_we), 32'd1);
        chk("sth_stall_cycles", 32'(nst), 32'd5);

        // Misaligned word load
        run_op(EXE_LD_W_OP, 32'h101, 32'h0, 32'h0, 0, nst, nreq, wbd, wreg_o, ale_o);
        chk("mis_ale", 32'(ale_o), 32'd1);
        chk("mis_req_cycles", 32'(nreq), 32'd0);
        chk("mis_stall_cycles", 32'(nst), 32'd0);
        chk("mis_wreg", 32'(wreg_o), 32'd0);

        // Flush in the second wait cycle, ack two cycles later
        mem_aluop = EXE_LD_W_OP; mem_mem_addr = 32'h300; mem_inst_valid = 1; data_rdata = 32'h1234;
        @(posedge clk); #1;
        @(posedge clk); #1 flush = 1;
        @(negedge clk);
        chk("fl_wb_valid", 32'(wb_inst_valid), 32'd0);
        chk("fl_wb_wreg", 32'(wb_wreg), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fl_drain_req", 32'(data_req), 32'd1);
        @(posedge clk); #1 data_ack = 1;
        @(negedge clk);
        chk("fl_drain_req2", 32'(data_req), 32'd1);
        chk("fl_drain_stall", 32'(stall_req), 32'd1);
        @(posedge clk); #1 data_ack = 0; flush = 0; bubble();
        @(negedge clk);
        chk("fl_idle_req", 32'(data_req), 32'd0);
        chk("fl_idle_stall", 32'(stall_req), 32'd0);
        run_op(EXE_LD_W_OP, 32'h400, 32'h0, 32'hCAFEF00D, 1, nst, nreq, wbd, wreg_o, ale_o);
        chk("fl_next_addr", cap_addr, 32'h400);
        chk("fl_next_wdata", wbd, 32'hCAFEF00D);

        // Reset while waiting
        mem_aluop = EXE_LD_W_OP; mem_mem_addr = 32'h500; mem_inst_valid = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_req", 32'(data_req), 32'd1);
        rst = 0;
        @(negedge clk);
        chk("rw_req_cleared", 32'(data_req), 32'd0);
        rst = 1;
        @(posedge clk); #1 bubble();
        run_op(EXE_LD_HU_OP, 32'h602, 32'h0, 32'h9876_5432, 2, nst, nreq, wbd, wreg_o, ale_o);
        chk("rw_after_wdata", wbd, 32'h00009876);

        // Random traffic against the model
        new_inst();
        repeat (3000) begin
            @(negedge clk);
            adv = !stall_req || flush || !rst;
            @(posedge clk); #1;
            if (adv) new_inst();
            flush = ($urandom_range(0, 11) == 0);
            data_ack = data_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            data_rdata = $urandom;
            rst = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-access stage placed directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It decodes load/store aluops, drives a req/ack data-bus port, and holds the pipeline with `stall_req` until the access completes. It also aligns and extends load data and computes store byte strobes. Non-memory instructions pass through combinationally with zero added latency.

## Interface
- `ADDR_W`, 32, data-bus address width
- `clk` in 1, rising-edge clock
- `rst` in 1, reset; synchronous, active-low (0 = reset)
- `flush` in 1, pipeline flush; squashes the instruction currently held in this stage
- `mem_wd`/`mem_wreg`/`mem_wdata`/`mem_inst_valid`/`mem_inst_pc` in 5/1/32/1/32, instruction fields from EX/MEM
- `mem_aluop` in `AluOpBus`, operation code; the memory ops are `EXE_LD_B/H/W/BU/HU_OP` and `EXE_ST_B/H/W_OP`
- `mem_mem_addr` in 32, effective address
- `mem_reg2` in 32, store data
- `wb_wd`/`wb_wreg`/`wb_wdata`/`wb_inst_valid`/`wb_inst_pc` out 5/1/32/1/32, fields to MEM/WB
- `ale` out 1, misaligned-address flag for the current instruction
- `stall_req` out 1, pipeline hold request to the stall controller
- `data_req` out 1, bus request, registered
- `data_we` out 1, write enable, registered
- `data_addr` out ADDR_W, word address with `[1:0]` forced to 0, registered
- `data_wstrb` out 4, byte strobes, registered
- `data_wdata` out 32, store data, registered
- `data_ack` in 1, one-cycle completion pulse
- `data_rdata` in 32, read word; valid when `data_ack`=1

## Operation
- State machine: IDLE, WAIT, DONE, DRAIN.
- `memop` = `mem_inst_valid` and the aluop is a load or store. `mis` = halfword with addr[0]=1, or word with addr[1:0]≠0. `ale` = `memop & mis`.
- IDLE:
  - If `memop & !mis & !flush`, load the bus registers, set `data_req`=1, and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Hold the bus outputs stable.
  - On `data_ack`, clear `data_req`, capture `data_rdata` into `rbuf`, and go to DONE. If `flush` is also high, go to DRAIN instead.
  - If `flush` arrives while `data_ack`=0, go to DRAIN.
- DRAIN: keep `data_req` high until `data_ack`, then go to IDLE. The captured data is discarded. The bus transaction is never abandoned.
- DONE: lasts one cycle; go to IDLE.
- `stall_req` = (`memop & !mis` & state∈{IDLE,WAIT}) | state==DRAIN. It is deasserted in DONE so that EX/MEM and MEM/WB advance on that edge.
- Stores:
  - `data_wstrb`: st.b = 4'b0001<<a; st.h = 4'b0011<<a; st.w = 4'b1111, where a = addr[1:0].
  - `data_wdata`: byte replicated ×4 for st.b, halfword ×2 for st.h, full word for st.w.
- Loads:
  - `data_we`=0 and `data_wstrb`=4'b0000.
  - Lane select: `rbuf[8a+7:8a]` for byte loads, `rbuf[16·a[1]+15:16·a[1]]` for halfword loads.
  - ld.b/ld.h sign-extend; ld.bu/ld.hu zero-extend; ld.w takes the word as is.
- Outputs to MEM/WB:
  - `wb_wdata` = aligned load data for loads, otherwise `mem_wdata`.
  - `wb_wreg` = `mem_wreg & !ale`.
  - All other `wb_*` fields pass through.
  - If `flush`=1, all `wb_*` outputs are zero.
- Misaligned access: no bus request, no stall, `ale`=1, and the instruction continues with its write suppressed.

## Timing
- Reset (`rst`=0 at an edge):
  - state → IDLE; `data_req`, `data_we`, `data_addr`, `data_wstrb`, `data_wdata` → 0; `rbuf` → 0.
  - Combinational outputs follow from the reset state: `stall_req`=0 when no memop is present.
  - Reset mid-WAIT abandons the bus transaction; the bus is reset together with this block.
- Access latency:
  - Edge 0: memop presented in IDLE.
  - Cycle 1: `data_req` visible.
  - First cycle `data_ack` is sampled high at edge N: DONE in cycle N+1, when result and `stall_req`=0 are visible.
  - With zero-wait ack (ack in cycle 1), the instruction occupies 3 cycles.
- Back-to-back memops: the next instruction arrives during DONE→IDLE and issues at the following edge. There is no bubble beyond the IDLE cycle.
- `data_ack` outside WAIT or DRAIN is ignored.

## Test plan
- Zero-wait load: ld.w addr 0x100, rdata 0xDEADBEEF, ack in the first req cycle -> `data_req` high for 1 cycle; `wb_wdata`=0xDEADBEEF in DONE; `stall_req` high for exactly 2 cycles.
- Sign-extended byte load: ld.b addr 0x103, rdata 0x80112233 -> `wb_wdata`=0xFFFFFF80. ld.bu at the same address -> 0x00000080.
- Store: st.h addr 0x202, reg2 0x0000ABCD -> `data_addr`=0x200, `data_wstrb`=4'b1100, `data_wdata`=0xABCDABCD, `data_we`=1. Ack after 3 wait cycles -> `stall_req` high for 5 cycles.
- Misaligned access: ld.w addr 0x101 -> `ale`=1, `data_req` never asserted, `stall_req`=0, `wb_wreg`=0.
- Flush mid-access: ld.w, flush in the 2nd WAIT cycle, ack 2 cycles later -> `data_req` held until ack; DRAIN → IDLE; `wb_*` zero throughout; a following memop issues only after DRAIN exits.
- Reset mid-WAIT: `rst`=0 for 1 cycle -> `data_req`=0 next cycle and state IDLE; a new load then completes normally.
